alu: RTL and testbench

//   Registered 64-bit integer ALU for the processor execute stage.

---
 rtl/alu.sv | 143 ++++++++++++++
 tb/tb_alu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu -- registered 64-bit integer ALU for the execute stage.
//
// Operations (control): 00 add, 01 sub, 10 and, 11 xor. The result and a
// signed-overflow flag are registered, so they appear one clock after the
// operands are sampled. There is no handshake, and a new operation is
// accepted every cycle.
//
// Add and sub share one ripple-carry chain built from gate-level full-adder
// slices. Sub is computed as a + ~b + 1: b is inverted and the carry-in is 1.
//
// Optional feature macro: ALU_CC_EN. When it is defined, the block adds the
// registered condition codes zf (out == 0) and sf (out[MSB]).
//
// Ports
//   clk      in   1      rising-edge clock
//   reset    in   1      asynchronous, active-high reset (clears out/c/zf/sf)
//   control  in   2      operation select
//   a, b     in   WIDTH  two's-complement operands
//   out      out  WIDTH  registered result (modulo 2**WIDTH)
//   c        out  1      registered signed-overflow flag (add/sub only)
//   zf, sf   out  1      registered zero / sign flags (ALU_CC_EN only)
// ---------------------------------------------------------------------------

// One full-adder bit slice.
module alu_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  logic w_p;
  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (w_p & i_ci);
endmodule

module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             c
`ifdef ALU_CC_EN
  ,
  output logic             zf,
  output logic             sf
`endif
);
  localparam int MSB = WIDTH - 1;

  // The shared adder is set to subtract when the select is 01. The B input
  // is inverted and the carry-in supplies the +1.
  logic             w_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_sub      = (control == 2'b01);
  assign w_b_eff    = b ^ {WIDTH{w_sub}};
  assign w_carry[0] = w_sub;

  // The ripple chain is an array of full-adder slices. Slice i drives carry i+1.
  alu_fa u_fa [WIDTH-1:0] (
    .i_a  (a),
    .i_b  (w_b_eff),
    .i_ci (w_carry[WIDTH-1:0]),
    .o_s  (w_sum),
    .o_co (w_carry[WIDTH:1])
  );

  // Signed overflow occurs when the carry into the sign bit differs from the
  // carry out of the sign bit. This matches the operand-sign rule for both add
  // and sub, because the sub path sees ~b. The final carry-out itself (the
  // unsigned carry/borrow) is not reported.
  logic             w_ovf_arith;
  assign w_ovf_arith = w_carry[WIDTH] ^ w_carry[MSB];

  logic [WIDTH-1:0] w_res;
  logic             w_ovf;

  always_comb begin
    w_res = w_sum;
    w_ovf = 1'b0;
    case (control)
      2'b00,
      2'b01: begin
        w_res = w_sum;
        w_ovf = w_ovf_arith;
      end
      2'b10:   w_res = a & b;
      2'b11:   w_res = a ^ b;
      default: begin
        // An unknown select is don't-care for this cycle only. The next
        // clean select fully determines the registered outputs.
        w_res = w_sum;
        w_ovf = 1'b0;
      end
    endcase
  end

  logic [WIDTH-1:0] r_out;
  logic             r_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out <= '0;
      r_c   <= 1'b0;
    end else begin
      r_out <= w_res;
      r_c   <= w_ovf;
    end
  end

  assign out = r_out;
  assign c   = r_c;

`ifdef ALU_CC_EN
  // The flags are taken from the same combinational result as out, so they
  // have the same latency and the same reset behaviour.
  logic r_zf;
  logic r_sf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zf <= 1'b0;
      r_sf <= 1'b0;
    end else begin
      r_zf <= (w_res == '0);
      r_sf <= w_res[MSB];
    end
  end

  assign zf = r_zf;
  assign sf = r_sf;
`endif

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu.
// Vectors are driven on the falling edge. The expected result is pushed to a
// scoreboard queue when an operation is driven. It is popped and compared 1
// time unit after the next rising edge.
// ---------------------------------------------------------------------------
module tb_alu;
  localparam int W = 64;
  localparam logic [W-1:0] ONES = {W{1'b1}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   control;
  logic [W-1:0] a, b;
  logic [W-1:0] out;
  logic         c;
`ifdef ALU_CC_EN
  logic         zf, sf;
`endif

  always #5 clk = ~clk;

  alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .control (control),
    .a       (a),
    .b       (b),
    .out     (out),
    .c       (c)
`ifdef ALU_CC_EN
    ,
    .zf      (zf),
    .sf      (sf)
`endif
  );

  typedef struct {
    logic [1:0]   ctl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] out;
    logic         c;
  } vec_t;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  int   n_run  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // The reference model uses 65-bit signed arithmetic. Overflow is detected
  // when the wide result does not fit in W bits.
  function automatic exp_t model(input string name, input logic [1:0] ctl,
                                 input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t m;
    logic signed [W:0] wide;
    m.name = name;
    m.c    = 1'b0;
    wide   = '0;
    case (ctl)
      2'b00: begin
        wide  = $signed({ia[W-1], ia}) + $signed({ib[W-1], ib});
        m.out = wide[W-1:0];
        m.c   = (wide[W] != wide[W-1]);
      end
      2'b01: begin
        wide  = $signed({ia[W-1], ia}) - $signed({ib[W-1], ib});
        m.out = wide[W-1:0];
        m.c   = (wide[W] != wide[W-1]);
      end
      2'b10:   m.out = ia & ib;
      default: m.out = ia ^ ib;
    endcase
    return m;
  endfunction

  task automatic collect();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries, expected at least 1", exp_q.size());
    end else begin
      e = exp_q.pop_front();
      check({e.name, " out"}, out, e.out);
      check({e.name, " c"}, {{(W-1){1'b0}}, c}, {{(W-1){1'b0}}, e.c});
`ifdef ALU_CC_EN
      check({e.name, " zf"}, {{(W-1){1'b0}}, zf}, {{(W-1){1'b0}}, (e.out == '0)});
      check({e.name, " sf"}, {{(W-1){1'b0}}, sf}, {{(W-1){1'b0}}, e.out[W-1]});
`endif
    end
  endtask

  // Call this at a falling edge. It drives one op, checks it after the next
  // rising edge, and returns at the following falling edge (one op per cycle).
  task automatic step(input string name, input logic [1:0] ctl,
                      input logic [W-1:0] ia, input logic [W-1:0] ib, input exp_t e);
    exp_t ee;
    ee      = e;
    ee.name = name;
    control = ctl;
    a       = ia;
    b       = ib;
    exp_q.push_back(ee);
    collect();
    @(negedge clk);
  endtask

  vec_t vecs[11];

  initial begin
    exp_t e;
    vecs[0]  = '{2'b00, MAXP,       64'd1, MINN,        1'b1};
    vecs[1]  = '{2'b00, 64'd63,     64'd63, 64'd126,    1'b0};
    vecs[2]  = '{2'b01, 64'd62,     64'd63, ONES,       1'b0};
    vecs[3]  = '{2'b01, MINN,       64'd1, MAXP,        1'b1};
    vecs[4]  = '{2'b10, 64'd62,     64'd63, 64'd62,     1'b0};
    vecs[5]  = '{2'b11, 64'd62,     64'd63, 64'd1,      1'b0};
    vecs[6]  = '{2'b01, 64'd5,      64'd5, 64'd0,       1'b0};
    vecs[7]  = '{2'b00, ONES,       64'd1, 64'd0,       1'b0};
    vecs[8]  = '{2'b01, 64'd0,      MINN,  MINN,        1'b1};
    vecs[9]  = '{2'b00, MINN,       MINN,  64'd0,       1'b1};
    vecs[10] = '{2'b10, MAXP,       ONES,  MAXP,        1'b0};

    // Reset with all-ones operands, which would otherwise add to ...FE.
    reset   = 1'b1;
    control = 2'b00;
    a       = ONES;
    b       = ONES;
    #1;
    check("reset_async out", out, '0);
    check("reset_async c", {{(W-1){1'b0}}, c}, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held out", out, '0);

    // Releasing reset does nothing until the next rising edge.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("release_no_edge out", out, '0);
    e = model("", 2'b00, ONES, ONES);
    exp_q.push_back('{"release_first_op", e.out, e.c});
    collect();
    @(negedge clk);

    // Directed vectors from the table.
    foreach (vecs[i]) begin
      e.out = vecs[i].out;
      e.c   = vecs[i].c;
      step($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].a, vecs[i].b, e);
    end

    // Sweep: back-to-back ops, with the operands stepping down from 63 to 56.
    for (int ctl = 0; ctl < 4; ctl++) begin
      for (int k = 0; k < 8; k++) begin
        logic [W-1:0] v;
        v = 64'(63 - k);
        e = model("", 2'(ctl), v, v - 64'(k % 3));
        step($sformatf("sweep ctl%0d k%0d", ctl, k), 2'(ctl), v, v - 64'(k % 3), e);
      end
    end

    // Random vectors.
    for (int k = 0; k < 16; k++) begin
      logic [W-1:0] ra, rb;
      logic [1:0]   rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 2'($urandom_range(3));
      e  = model("", rc, ra, rb);
      step($sformatf("rand%0d", k), rc, ra, rb, e);
    end

    // Reset mid-stream. The first add completes. The second add is discarded.
    e = model("", 2'b00, 64'd3, 64'd4);
    step("mid_first_add", 2'b00, 64'd3, 64'd4, e);
    control = 2'b00;
    a       = 64'd10;
    b       = 64'd20;
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_async out", out, '0);
    check("mid_reset_async c", {{(W-1){1'b0}}, c}, '0);
    @(posedge clk);
    #1;
    check("mid_reset_no_second_add", out, '0);
    @(negedge clk);
    reset = 1'b0;
    e = model("", 2'b10, 64'hF0, 64'h3C);
    step("after_mid_reset", 2'b10, 64'hF0, 64'h3C, e);

    check("scoreboard_drained", 64'(exp_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
